seg_scan_decoder: RTL and testbench
===================================

# seg_scan_decoder

Receive-side monitor for the multiplexed seven-segment display bus: samples the active-low anode and cathode lines, recovers the 4-bit digit shown on each anode position and presents a complete, error-flagged display value once every position has been refreshed. It sits beside the display driver (or on pins looped back from the board) for built-in readback checking and for benches that score display content without a scope.

## Interface
- `N_DIGITS`, 4: number of anode positions (1..8).
- `STABLE_CYCLES`, 8: consecutive identical synchronized samples required before a digit is captured (≥1).
- `clk`  in  1  system clock; sole clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `an_in`  in  N_DIGITS  anode enables, active-low; bit i = position i; asynchronous to `clk`.
- `seg_in`  in  7  cathodes, active-low; bit0 = a … bit6 = g; asynchronous to `clk`.
- `value_out`  out  4*N_DIGITS  decoded digits; nibble i = position i.
- `digit_err`  out  N_DIGITS  bit i set = position i showed an undecodable pattern in the last frame.
- `err_any`  out  1  OR of `digit_err`.
- `frame_valid`  out  1  one-cycle pulse when `value_out`/`digit_err` update.
- `value_valid`  out  1  high from the first completed frame until reset.

## Operation
- Input stage: two-flop synchronizer on `an_in` and `seg_in`; both flops reset to all-ones (display dark).
- Anode decode: exactly one `an_s` bit low → active position index; zero or more than one low → no active position.
- FSM, registered state:
  - IDLE: no active position. → SETTLE when exactly one anode low.
  - SETTLE: stability counter increments each cycle `{an_s, seg_s}` equals previous sample; any change restarts the counter at 1 (→ IDLE if no active position). Counter reaching `STABLE_CYCLES` → capture, → HOLD.
  - HOLD: one capture per dwell; stays until `{an_s, seg_s}` changes, then → SETTLE (or IDLE).
- Capture: segment pattern decoded, written to shadow nibble and shadow error bit of the active position; that position's `seen` bit set. Re-capture of an already-seen position in the same frame overwrites its shadow.
- Decode (inverse of the display encoder): 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9, 1111111 (blank)→4'hF with no error; any other pattern →4'hE with error set.
- All-segments-lit decodes as 8; the encoder's default/overflow "full" pattern is indistinguishable from 8 by design.
- Frame completion: when `seen` becomes all-ones, next cycle copies shadow to `value_out`/`digit_err`, pulses `frame_valid`, sets `value_valid`, clears `seen`. Outputs never mix two frames.
- Capture in the completion cycle is accepted into shadow and counts toward the next frame.

## Timing
- Reset values: `value_out` 0, `digit_err` 0, `err_any` 0, `frame_valid` 0, `value_valid` 0; FSM IDLE, counter 0, `seen` 0, shadows 0, synchronizers all-ones.
- Pin-to-capture latency: 2 sync cycles + `STABLE_CYCLES` cycles of stable input.
- Capture-to-output: last position captured in cycle t → `frame_valid` high and new `value_out` in cycle t+1; `err_any` registered, same cycle.
- Stability counter width clog2(`STABLE_CYCLES`+1), saturating; glitch shorter than `STABLE_CYCLES` never captures.
- Reset asserted mid-frame: partial frame discarded, no `frame_valid`; output held at reset values until a full new frame completes.

## Structure
- Shared package `seg_pkg`: active-low segment constants SEG_0…SEG_9, SEG_BLANK, DIGIT_BLANK (4'hF), DIGIT_ERR (4'hE), FSM state typedef.
- Sub-module `seg2bin`: purely combinational, 7-bit pattern in → {err, 4-bit digit} out; reused by benches as a reference model.
- Top holds synchronizers, FSM, counter, `seen`, shadow and output registers.

## Test plan
- Scan 1,2,3,4 on positions 0..3, 16-cycle dwell each, `STABLE_CYCLES`=8 → one `frame_valid`, `value_out`=16'h4321, `digit_err`=0, `value_valid`=1.
- Position 2 shows 1111111 → nibble 2 = 4'hF, no error; shows 0001000 → nibble 2 = 4'hE, `digit_err`=4'b0100, `err_any`=1.
- 5-cycle glitch to pattern 0100100 inside a 7-segment dwell → no capture of 2; stable value retained.
- Two anodes low simultaneously for 20 cycles → no captures, `seen` unchanged, no `frame_valid`.
- Positions 0,1,2 captured then `reset` → all outputs 0; new full scan 9,8,7,6 → `value_out`=16'h6789 after exactly one `frame_valid`.
- Position 0 rescanned with 5 then 6 before positions 1..3 → frame reports nibble 0 = 6.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan monitor.
// Segment patterns are active-low, bit0 = a ... bit6 = g.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b100_0000;
    localparam logic [6:0] SEG_1     = 7'b111_1001;
    localparam logic [6:0] SEG_2     = 7'b010_0100;
    localparam logic [6:0] SEG_3     = 7'b011_0000;
    localparam logic [6:0] SEG_4     = 7'b001_1001;
    localparam logic [6:0] SEG_5     = 7'b001_0010;
    localparam logic [6:0] SEG_6     = 7'b000_0010;
    localparam logic [6:0] SEG_7     = 7'b111_1000;
    localparam logic [6:0] SEG_8     = 7'b000_0000;
    localparam logic [6:0] SEG_9     = 7'b001_0000;
    localparam logic [6:0] SEG_BLANK = 7'b111_1111;

    localparam logic [3:0] DIGIT_BLANK = 4'hF;
    localparam logic [3:0] DIGIT_ERR   = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } scan_state_e;

endpackage

// File: rtl/seg_scan_decoder_seg2bin.sv
// Combinational inverse of the display encoder: active-low pattern to digit.
// Unknown patterns return DIGIT_ERR with the error flag raised.
module seg2bin
    import seg_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_digit,
    output logic       o_err
);

    // Pattern lookup; the all-lit "full" pattern is deliberately just an 8
    always_comb begin
        o_digit = DIGIT_ERR;
        o_err   = 1'b1;
        case (i_seg)
            SEG_0:     begin o_digit = 4'h0;        o_err = 1'b0; end
            SEG_1:     begin o_digit = 4'h1;        o_err = 1'b0; end
            SEG_2:     begin o_digit = 4'h2;        o_err = 1'b0; end
            SEG_3:     begin o_digit = 4'h3;        o_err = 1'b0; end
            SEG_4:     begin o_digit = 4'h4;        o_err = 1'b0; end
            SEG_5:     begin o_digit = 4'h5;        o_err = 1'b0; end
            SEG_6:     begin o_digit = 4'h6;        o_err = 1'b0; end
            SEG_7:     begin o_digit = 4'h7;        o_err = 1'b0; end
            SEG_8:     begin o_digit = 4'h8;        o_err = 1'b0; end
            SEG_9:     begin o_digit = 4'h9;        o_err = 1'b0; end
            SEG_BLANK: begin o_digit = DIGIT_BLANK; o_err = 1'b0; end
            default:   begin o_digit = DIGIT_ERR;   o_err = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive-side monitor for a multiplexed seven-segment bus: recovers each
// position's digit and publishes a whole frame once every position was seen.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int N_DIGITS      = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_DIGITS-1:0]   an_in,
    input  logic [6:0]            seg_in,
    output logic [4*N_DIGITS-1:0] value_out,
    output logic [N_DIGITS-1:0]   digit_err,
    output logic                  err_any,
    output logic                  frame_valid,
    output logic                  value_valid
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int SW = N_DIGITS + 7;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [N_DIGITS-1:0]   r_an_meta, r_an_s;
    logic [6:0]            r_seg_meta, r_seg_s;
    logic [SW-1:0]         r_prev;
    scan_state_e           r_state, w_state_next;
    logic [CW-1:0]         r_cnt, w_cnt_next, w_cnt_inc;
    logic [N_DIGITS-1:0]   r_seen, w_seen_next;
    logic [4*N_DIGITS-1:0] r_sh_val, w_sh_val_next;
    logic [N_DIGITS-1:0]   r_sh_err, w_sh_err_next;
    logic [4*N_DIGITS-1:0] r_value_out;
    logic [N_DIGITS-1:0]   r_digit_err;
    logic                  r_err_any, r_frame_valid, r_value_valid;

    logic [SW-1:0]         w_cur;
    logic                  w_same, w_active, w_capture, w_frame_done;
    logic [3:0]            w_low_cnt;
    logic [IW-1:0]         w_idx;
    logic [3:0]            w_dec_digit;
    logic                  w_dec_err;

    // Two-flop synchronizers plus the previous-sample register; dark after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_an_meta  <= '1;
            r_an_s     <= '1;
            r_seg_meta <= 7'h7F;
            r_seg_s    <= 7'h7F;
            r_prev     <= '1;
        end else begin
            r_an_meta  <= an_in;
            r_an_s     <= r_an_meta;
            r_seg_meta <= seg_in;
            r_seg_s    <= r_seg_meta;
            r_prev     <= w_cur;
        end
    end

    assign w_cur     = {r_an_s, r_seg_s};
    assign w_same    = (w_cur == r_prev);
    assign w_cnt_inc = (r_cnt >= CNT_MAX) ? CNT_MAX : (r_cnt + CNT_ONE);
    assign w_active  = (w_low_cnt == 4'd1);

    // Anode decode: only a single low anode names an active position
    always_comb begin
        w_low_cnt = 4'd0;
        w_idx     = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!r_an_s[i]) begin
                w_low_cnt = w_low_cnt + 4'd1;
                w_idx     = IW'(i);
            end else begin
                w_low_cnt = w_low_cnt;
            end
        end
    end

    seg2bin u_seg2bin (
        .i_seg   (r_seg_s),
        .o_digit (w_dec_digit),
        .o_err   (w_dec_err)
    );

    // Scan FSM next state; capture fires once when the dwell has been stable long enough
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_active) begin
                    w_state_next = ST_SETTLE;
                    w_cnt_next   = CNT_ONE;
                end else begin
                    w_cnt_next   = {CW{1'b0}};
                end
            end
            ST_SETTLE: begin
                if (!w_same) begin
                    w_cnt_next   = CNT_ONE;
                    w_state_next = w_active ? ST_SETTLE : ST_IDLE;
                end else begin
                    w_cnt_next   = w_cnt_inc;
                end
            end
            ST_HOLD: begin
                if (!w_same) begin
                    w_cnt_next   = CNT_ONE;
                    w_state_next = w_active ? ST_SETTLE : ST_IDLE;
                end else begin
                    w_cnt_next   = w_cnt_inc;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = {CW{1'b0}};
            end
        endcase
        if (w_active && (w_state_next == ST_SETTLE) && (w_cnt_next >= CNT_MAX)) begin
            w_capture    = 1'b1;
            w_state_next = ST_HOLD;
        end else begin
            w_capture    = 1'b0;
        end
    end

    // FSM state and stability counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= {CW{1'b0}};
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Shadow update for the captured position; frame is complete once all are seen
    always_comb begin
        w_sh_val_next = r_sh_val;
        w_sh_err_next = r_sh_err;
        w_seen_next   = r_seen;
        if (w_capture) begin
            w_sh_val_next[{w_idx, 2'b00} +: 4] = w_dec_digit;
            w_sh_err_next[w_idx]               = w_dec_err;
            w_seen_next[w_idx]                 = 1'b1;
        end else begin
            w_seen_next = r_seen;
        end
    end

    assign w_frame_done = &w_seen_next;

    // Shadow and output registers; outputs only ever change as a whole frame
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sh_val      <= '0;
            r_sh_err      <= '0;
            r_seen        <= '0;
            r_value_out   <= '0;
            r_digit_err   <= '0;
            r_err_any     <= 1'b0;
            r_frame_valid <= 1'b0;
            r_value_valid <= 1'b0;
        end else begin
            r_sh_val      <= w_sh_val_next;
            r_sh_err      <= w_sh_err_next;
            r_frame_valid <= w_frame_done;
            if (w_frame_done) begin
                r_seen        <= '0;
                r_value_out   <= w_sh_val_next;
                r_digit_err   <= w_sh_err_next;
                r_err_any     <= |w_sh_err_next;
                r_value_valid <= 1'b1;
            end else begin
                r_seen        <= w_seen_next;
            end
        end
    end

    assign value_out   = r_value_out;
    assign digit_err   = r_digit_err;
    assign err_any     = r_err_any;
    assign frame_valid = r_frame_valid;
    assign value_valid = r_value_valid;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: table-driven frames plus
// hand-written glitch, dual-anode, reset and rescan sequences.
module tb_seg_scan_decoder;

    localparam logic [6:0] P0 = 7'b100_0000;
    localparam logic [6:0] P1 = 7'b111_1001;
    localparam logic [6:0] P2 = 7'b010_0100;
    localparam logic [6:0] P3 = 7'b011_0000;
    localparam logic [6:0] P4 = 7'b001_1001;
    localparam logic [6:0] P5 = 7'b001_0010;
    localparam logic [6:0] P6 = 7'b000_0010;
    localparam logic [6:0] P7 = 7'b111_1000;
    localparam logic [6:0] P8 = 7'b000_0000;
    localparam logic [6:0] P9 = 7'b001_0000;
    localparam logic [6:0] PB = 7'b111_1111;

    typedef struct packed {
        logic [15:0] val;
        logic [3:0]  err;
    } exp_t;

    typedef struct {
        logic [27:0] pats;
        logic [15:0] val;
        logic [3:0]  err;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  an_in;
    logic [6:0]  seg_in;
    logic [15:0] value_out;
    logic [3:0]  digit_err;
    logic        err_any, frame_valid, value_valid;

    int   checks = 0;
    int   failures = 0;
    int   fv_count = 0;
    int   fv_before;
    exp_t exp_q[$];
    vec_t vecs[0:4];

    seg_scan_decoder #(.N_DIGITS(4), .STABLE_CYCLES(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .an_in       (an_in),
        .seg_in      (seg_in),
        .value_out   (value_out),
        .digit_err   (digit_err),
        .err_any     (err_any),
        .frame_valid (frame_valid),
        .value_valid (value_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard: each frame_valid pulse pops and compares one expected frame
    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            exp_t e;
            fv_count++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame actual=%h required=none", value_out);
            end else begin
                e = exp_q.pop_front();
                chk("value_out", 32'(value_out), 32'(e.val));
                chk("digit_err", 32'(digit_err), 32'(e.err));
                chk("err_any", 32'(err_any), 32'(e.err != 4'd0));
                chk("value_valid", 32'(value_valid), 32'd1);
            end
        end
    end

    task automatic show(input logic [3:0] an, input logic [6:0] seg, input int n);
        an_in  = an;
        seg_in = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pos(input int p, input logic [6:0] seg, input int n);
        show(~(4'b0001 << p), seg, n);
    endtask

    task automatic scan4(input logic [27:0] pats);
        for (int p = 0; p < 4; p++) pos(p, pats[p*7 +: 7], 16);
        show(4'hF, PB, 4);
    endtask

    task automatic push(input logic [15:0] v, input logic [3:0] e);
        exp_t x;
        x.val = v;
        x.err = e;
        exp_q.push_back(x);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout actual=%0d pending required=0", name, exp_q.size());
            exp_q.delete();
        end
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_value_out"}, 32'(value_out), 32'd0);
        chk({tag, "_digit_err"}, 32'(digit_err), 32'd0);
        chk({tag, "_err_any"}, 32'(err_any), 32'd0);
        chk({tag, "_frame_valid"}, 32'(frame_valid), 32'd0);
        chk({tag, "_value_valid"}, 32'(value_valid), 32'd0);
    endtask

    initial begin
        vecs[0] = '{pats: {P4, P3, P2, P1}, val: 16'h4321, err: 4'b0000};
        vecs[1] = '{pats: {P3, PB, P1, P0}, val: 16'h3F10, err: 4'b0000};
        vecs[2] = '{pats: {P7, 7'b000_1000, P6, P5}, val: 16'h7E65, err: 4'b0100};
        vecs[3] = '{pats: {P0, P8, P9, P8}, val: 16'h0898, err: 4'b0000};
        vecs[4] = '{pats: {7'b101_0101, P9, P4, 7'b000_0001}, val: 16'hE94E, err: 4'b1001};

        reset  = 1'b1;
        an_in  = 4'hF;
        seg_in = PB;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk_reset_outputs("reset");

        foreach (vecs[v]) begin
            fv_before = fv_count;
            push(vecs[v].val, vecs[v].err);
            scan4(vecs[v].pats);
            drain("vec");
            chk("vec_frame_count", 32'(fv_count - fv_before), 32'd1);
            chk("vec_hold_value", 32'(value_out), 32'(vecs[v].val));
        end

        // Short glitch to "2" after a captured "7" must not be captured
        fv_before = fv_count;
        push(16'h3217, 4'b0000);
        pos(0, P7, 16);
        pos(0, P2, 5);
        pos(1, P1, 16);
        pos(2, P2, 16);
        pos(3, P3, 16);
        show(4'hF, PB, 4);
        drain("glitch");
        chk("glitch_frame_count", 32'(fv_count - fv_before), 32'd1);

        // Two anodes low must neither capture nor complete the frame
        fv_before = fv_count;
        push(16'h4321, 4'b0000);
        pos(0, P1, 16);
        pos(1, P2, 16);
        pos(2, P3, 16);
        show(4'b0110, P8, 20);
        chk("dual_anode_no_frame", 32'(fv_count - fv_before), 32'd0);
        pos(3, P4, 16);
        show(4'hF, PB, 4);
        drain("dual");
        chk("dual_frame_count", 32'(fv_count - fv_before), 32'd1);

        // Reset mid-frame discards the partial frame
        pos(0, P5, 16);
        pos(1, P5, 16);
        pos(2, P5, 16);
        reset = 1'b1;
        show(4'hF, PB, 2);
        reset = 1'b0;
        chk_reset_outputs("midreset");
        fv_before = fv_count;
        push(16'h6789, 4'b0000);
        scan4({P6, P7, P8, P9});
        drain("post_reset");
        chk("post_reset_frame_count", 32'(fv_count - fv_before), 32'd1);

        // Rescan of position 0 within one frame keeps the latest value
        fv_before = fv_count;
        push(16'h3216, 4'b0000);
        pos(0, P5, 16);
        pos(0, P6, 16);
        pos(1, P1, 16);
        pos(2, P2, 16);
        pos(3, P3, 16);
        show(4'hF, PB, 4);
        drain("rescan");
        chk("rescan_frame_count", 32'(fv_count - fv_before), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
